// File: rtl/pclk_tap_calibrator.sv
// Pixel-clock capture phase calibrator: sweeps the delay-line taps against an
// alternating training pattern, then parks the tap at the centre of the widest passing eye.
module pclk_tap_calibrator #(
    parameter int unsigned NUM_TAPS = 8,
    parameter int unsigned TAP_W    = 3,
    parameter int unsigned DATA_W   = 10,
    parameter logic [DATA_W-1:0] PAT_A = DATA_W'(10'h2AA),
    parameter int unsigned SETTLE   = 16,
    parameter int unsigned SAMPLES  = 64,
    parameter int unsigned MIN_EYE  = 2,
    parameter int unsigned DEF_TAP  = 4
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSTART,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    output logic [TAP_W-1:0]  oTAP,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oLOCK,
    output logic              oFAIL,
    output logic [TAP_W-1:0]  oEYE_START,
    output logic [TAP_W:0]    oEYE_WIDTH
);

    localparam int unsigned SET_W = $clog2(SETTLE) + 1;
    localparam int unsigned SMP_W = $clog2(SAMPLES) + 1;
    localparam int unsigned RUN_W = TAP_W + 1;

    typedef enum logic [2:0] {
        sIdle,
        sSettle,
        sCheck,
        sNext,
        sPick,
        sFinish
    } stateT;

    stateT             state,     stateN;
    logic [TAP_W-1:0]  tapIdx,    tapIdxN;
    logic [TAP_W-1:0]  tapQ,      tapN;
    logic [SET_W-1:0]  settleCnt, settleCntN;
    logic [SMP_W-1:0]  sampleCnt, sampleCntN;
    logic              errFlag,   errFlagN;
    logic              prevValid, prevValidN;
    logic [DATA_W-1:0] prevWord,  prevWordN;
    logic [RUN_W-1:0]  runLen,    runLenN;
    logic [TAP_W-1:0]  runStart,  runStartN;
    logic [RUN_W-1:0]  bestLen,   bestLenN;
    logic [TAP_W-1:0]  bestStart, bestStartN;
    logic              busyQ,     busyN;
    logic              doneQ,     doneN;
    logic              lockQ,     lockN;
    logic              failQ,     failN;
    logic [TAP_W-1:0]  eyeStartQ, eyeStartN;
    logic [RUN_W-1:0]  eyeWidthQ, eyeWidthN;
    logic [RUN_W-1:0]  runCand;
    logic [TAP_W-1:0]  startCand;

    assign oTAP       = tapQ;
    assign oBUSY      = busyQ;
    assign oDONE      = doneQ;
    assign oLOCK      = lockQ;
    assign oFAIL      = failQ;
    assign oEYE_START = eyeStartQ;
    assign oEYE_WIDTH = eyeWidthQ;

    // State and datapath registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= sIdle;
            tapIdx    <= '0;
            tapQ      <= TAP_W'(DEF_TAP);
            settleCnt <= '0;
            sampleCnt <= '0;
            errFlag   <= 1'b0;
            prevValid <= 1'b0;
            prevWord  <= '0;
            runLen    <= '0;
            runStart  <= '0;
            bestLen   <= '0;
            bestStart <= '0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
            lockQ     <= 1'b0;
            failQ     <= 1'b0;
            eyeStartQ <= '0;
            eyeWidthQ <= '0;
        end else begin
            state     <= stateN;
            tapIdx    <= tapIdxN;
            tapQ      <= tapN;
            settleCnt <= settleCntN;
            sampleCnt <= sampleCntN;
            errFlag   <= errFlagN;
            prevValid <= prevValidN;
            prevWord  <= prevWordN;
            runLen    <= runLenN;
            runStart  <= runStartN;
            bestLen   <= bestLenN;
            bestStart <= bestStartN;
            busyQ     <= busyN;
            doneQ     <= doneN;
            lockQ     <= lockN;
            failQ     <= failN;
            eyeStartQ <= eyeStartN;
            eyeWidthQ <= eyeWidthN;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateN     = state;
        tapIdxN    = tapIdx;
        tapN       = tapQ;
        settleCntN = settleCnt;
        sampleCntN = sampleCnt;
        errFlagN   = errFlag;
        prevValidN = prevValid;
        prevWordN  = prevWord;
        runLenN    = runLen;
        runStartN  = runStart;
        bestLenN   = bestLen;
        bestStartN = bestStart;
        busyN      = busyQ;
        doneN      = 1'b0;
        lockN      = lockQ;
        failN      = failQ;
        eyeStartN  = eyeStartQ;
        eyeWidthN  = eyeWidthQ;
        runCand    = '0;
        startCand  = runStart;

        case (state)
            sIdle: begin
                if (iSTART) begin
                    stateN     = sSettle;
                    tapN       = '0;
                    tapIdxN    = '0;
                    settleCntN = '0;
                    runLenN    = '0;
                    runStartN  = '0;
                    bestLenN   = '0;
                    bestStartN = '0;
                    lockN      = 1'b0;
                    failN      = 1'b0;
                    busyN      = 1'b1;
                end
            end

            sSettle: begin
                if (settleCnt == SET_W'(SETTLE)) begin
                    stateN     = sCheck;
                    errFlagN   = 1'b0;
                    sampleCntN = '0;
                    prevValidN = 1'b0;
                end else begin
                    settleCntN = settleCnt + SET_W'(1);
                end
            end

            // Only valid words advance the count or the alternation reference
            sCheck: begin
                if (iDVAL) begin
                    if (prevValid) begin
                        if (iDATA != ~prevWord) errFlagN = 1'b1;
                    end else if ((iDATA != PAT_A) && (iDATA != ~PAT_A)) begin
                        errFlagN = 1'b1;
                    end
                    prevWordN  = iDATA;
                    prevValidN = 1'b1;
                    if (sampleCnt == SMP_W'(SAMPLES - 1)) begin
                        stateN = sNext;
                    end else begin
                        sampleCntN = sampleCnt + SMP_W'(1);
                    end
                end
            end

            sNext: begin
                if (!errFlag) begin
                    runCand   = runLen + RUN_W'(1);
                    startCand = (runLen == '0) ? tapIdx : runStart;
                end
                runLenN   = runCand;
                runStartN = startCand;
                // Strict compare keeps the lower-tap eye on a tie
                if (runCand > bestLen) begin
                    bestLenN   = runCand;
                    bestStartN = startCand;
                end
                if (tapIdx == TAP_W'(NUM_TAPS - 1)) begin
                    stateN = sPick;
                end else begin
                    tapIdxN    = tapIdx + TAP_W'(1);
                    tapN       = tapIdx + TAP_W'(1);
                    settleCntN = '0;
                    stateN     = sSettle;
                end
            end

            sPick: begin
                eyeStartN = bestStart;
                eyeWidthN = bestLen;
                if (bestLen >= RUN_W'(MIN_EYE)) begin
                    tapN  = bestStart + TAP_W'((bestLen - RUN_W'(1)) >> 1);
                    lockN = 1'b1;
                end else begin
                    tapN  = TAP_W'(DEF_TAP);
                    failN = 1'b1;
                end
                busyN  = 1'b0;
                doneN  = 1'b1;
                stateN = sFinish;
            end

            sFinish: begin
                stateN = sIdle;
            end

            default: begin
                stateN = sIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_pclk_tap_calibrator.sv
// Directed bench for pclk_tap_calibrator: a behavioural delay line returns clean
// 2AA/155 alternation on taps in passMask and corrupted words elsewhere.
module tb_pclk_tap_calibrator;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       iSTART;
    logic [9:0] iDATA;
    logic       iDVAL;
    logic [2:0] oTAP;
    logic       oBUSY;
    logic       oDONE;
    logic       oLOCK;
    logic       oFAIL;
    logic [2:0] oEYE_START;
    logic [3:0] oEYE_WIDTH;

    int tests = 0;
    int fails = 0;

    logic [7:0] passMask = 8'h00;
    bit         gapMode  = 1'b0;

    pclk_tap_calibrator dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSTART     (iSTART),
        .iDATA      (iDATA),
        .iDVAL      (iDVAL),
        .oTAP       (oTAP),
        .oBUSY      (oBUSY),
        .oDONE      (oDONE),
        .oLOCK      (oLOCK),
        .oFAIL      (oFAIL),
        .oEYE_START (oEYE_START),
        .oEYE_WIDTH (oEYE_WIDTH)
    );

    always #5 iCLK = ~iCLK;

    // Delay-line model: good taps alternate, bad taps return a non-pattern word
    initial begin
        int  gapCnt;
        bit  phase;
        bit  dvalNow;
        gapCnt = 0;
        phase  = 1'b0;
        iDATA  = '0;
        iDVAL  = 1'b0;
        forever begin
            @(negedge iCLK);
            gapCnt  = (gapCnt + 1) % 3;
            dvalNow = !gapMode || (gapCnt == 0);
            iDVAL   = dvalNow;
            if (!dvalNow) begin
                iDATA = 10'h3FF;
            end else if (passMask[oTAP]) begin
                iDATA = phase ? 10'h155 : 10'h2AA;
                phase = ~phase;
            end else begin
                iDATA = 10'h0F0;
            end
        end
    end

    task automatic run_cal(input int retrigAt, output int cycles, output bit timedOut,
                           output bit busyAtDone, output int extraDones,
                           output bit busyEarly, output bit lockEarly, output bit failEarly);
        @(negedge iCLK);
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART     = 1'b0;
        cycles     = 1;
        timedOut   = 1'b1;
        busyAtDone = 1'b1;
        extraDones = 0;
        busyEarly  = oBUSY;
        lockEarly  = oLOCK;
        failEarly  = oFAIL;
        while (cycles < 10000) begin
            @(negedge iCLK);
            cycles++;
            iSTART = (cycles == retrigAt);
            if (oDONE) begin
                timedOut   = 1'b0;
                busyAtDone = oBUSY;
                break;
            end
        end
        iSTART = 1'b0;
        repeat (40) begin
            @(negedge iCLK);
            if (oDONE) extraDones++;
        end
    endtask

    task automatic test_reset();
        int doneSeen;
        iRST   = 1'b1;
        iSTART = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);
        tests++; if (oTAP !== 3'd4) begin fails++; $display("FAIL reset_tap: got %0d expected 4", oTAP); end
        tests++; if (oBUSY !== 1'b0 || oLOCK !== 1'b0 || oFAIL !== 1'b0 || oDONE !== 1'b0) begin
            fails++; $display("FAIL reset_flags: busy=%0b lock=%0b fail=%0b done=%0b expected all 0", oBUSY, oLOCK, oFAIL, oDONE);
        end
        tests++; if (oEYE_START !== 3'd0 || oEYE_WIDTH !== 4'd0) begin
            fails++; $display("FAIL reset_eye: start=%0d width=%0d expected 0/0", oEYE_START, oEYE_WIDTH);
        end
        doneSeen = 0;
        repeat (50) begin
            @(negedge iCLK);
            if (oDONE) doneSeen++;
        end
        tests++; if (doneSeen != 0 || oBUSY !== 1'b0) begin
            fails++; $display("FAIL idle_quiet: done pulses=%0d busy=%0b expected 0/0", doneSeen, oBUSY);
        end
    endtask

    task automatic test_single_eye();
        int cycles, extra;
        bit timedOut, busyAtDone, bE, lE, fE;
        passMask = 8'b0111_1100;
        gapMode  = 1'b0;
        run_cal(0, cycles, timedOut, busyAtDone, extra, bE, lE, fE);
        tests++; if (timedOut) begin fails++; $display("FAIL single_done: got timeout expected oDONE"); end
        tests++; if (bE !== 1'b1) begin fails++; $display("FAIL single_busy: got %0b expected 1", bE); end
        tests++; if (cycles != 658) begin fails++; $display("FAIL single_latency: got %0d expected 658", cycles); end
        tests++; if (busyAtDone !== 1'b0 || extra != 0) begin
            fails++; $display("FAIL single_pulse: busyAtDone=%0b extra=%0d expected 0/0", busyAtDone, extra);
        end
        tests++; if (oLOCK !== 1'b1 || oFAIL !== 1'b0 || oTAP !== 3'd4) begin
            fails++; $display("FAIL single_lock: lock=%0b fail=%0b tap=%0d expected 1/0/4", oLOCK, oFAIL, oTAP);
        end
        tests++; if (oEYE_START !== 3'd2 || oEYE_WIDTH !== 4'd5) begin
            fails++; $display("FAIL single_eye: start=%0d width=%0d expected 2/5", oEYE_START, oEYE_WIDTH);
        end
    endtask

    task automatic test_tie();
        int cycles, extra;
        bit timedOut, busyAtDone, bE, lE, fE;
        passMask = 8'b0110_0011;
        run_cal(0, cycles, timedOut, busyAtDone, extra, bE, lE, fE);
        tests++; if (lE !== 1'b0) begin fails++; $display("FAIL tie_lock_clear: got %0b expected 0", lE); end
        tests++; if (timedOut || extra != 0) begin
            fails++; $display("FAIL tie_done: timeout=%0b extra=%0d expected 0/0", timedOut, extra);
        end
        tests++; if (oLOCK !== 1'b1 || oTAP !== 3'd0) begin
            fails++; $display("FAIL tie_lock: lock=%0b tap=%0d expected 1/0", oLOCK, oTAP);
        end
        tests++; if (oEYE_START !== 3'd0 || oEYE_WIDTH !== 4'd2) begin
            fails++; $display("FAIL tie_eye: start=%0d width=%0d expected 0/2", oEYE_START, oEYE_WIDTH);
        end
    endtask

    task automatic test_narrow();
        int cycles, extra;
        bit timedOut, busyAtDone, bE, lE, fE;
        passMask = 8'b1000_0000;
        run_cal(0, cycles, timedOut, busyAtDone, extra, bE, lE, fE);
        tests++; if (timedOut) begin fails++; $display("FAIL narrow_done: got timeout expected oDONE"); end
        tests++; if (oFAIL !== 1'b1 || oLOCK !== 1'b0 || oTAP !== 3'd4) begin
            fails++; $display("FAIL narrow_fail: fail=%0b lock=%0b tap=%0d expected 1/0/4", oFAIL, oLOCK, oTAP);
        end
        tests++; if (oEYE_START !== 3'd7 || oEYE_WIDTH !== 4'd1) begin
            fails++; $display("FAIL narrow_eye: start=%0d width=%0d expected 7/1", oEYE_START, oEYE_WIDTH);
        end
        repeat (20) @(negedge iCLK);
        tests++; if (oFAIL !== 1'b1 || oTAP !== 3'd4 || oEYE_START !== 3'd7) begin
            fails++; $display("FAIL narrow_hold: fail=%0b tap=%0d start=%0d expected 1/4/7", oFAIL, oTAP, oEYE_START);
        end
    endtask

    task automatic test_gaps_retrigger();
        int cycles, extra;
        bit timedOut, busyAtDone, bE, lE, fE;
        passMask = 8'hFF;
        gapMode  = 1'b1;
        run_cal(300, cycles, timedOut, busyAtDone, extra, bE, lE, fE);
        gapMode = 1'b0;
        tests++; if (fE !== 1'b0) begin fails++; $display("FAIL gaps_fail_clear: got %0b expected 0", fE); end
        tests++; if (timedOut || extra != 0) begin
            fails++; $display("FAIL gaps_done: timeout=%0b extra=%0d expected 0/0", timedOut, extra);
        end
        tests++; if (oLOCK !== 1'b1 || oTAP !== 3'd3) begin
            fails++; $display("FAIL gaps_lock: lock=%0b tap=%0d expected 1/3", oLOCK, oTAP);
        end
        tests++; if (oEYE_START !== 3'd0 || oEYE_WIDTH !== 4'd8) begin
            fails++; $display("FAIL gaps_eye: start=%0d width=%0d expected 0/8", oEYE_START, oEYE_WIDTH);
        end
    endtask

    task automatic test_reset_mid_check();
        int n, cycles, extra;
        bit timedOut, busyAtDone, bE, lE, fE;
        passMask = 8'b0111_1100;
        @(negedge iCLK);
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        n = 0;
        while (oTAP != 3'd3 && n < 5000) begin
            @(negedge iCLK);
            n++;
        end
        tests++; if (n >= 5000) begin fails++; $display("FAIL midrst_reach: tap=%0d expected 3", oTAP); end
        repeat (27) @(negedge iCLK);
        tests++; if (oTAP !== 3'd3 || oBUSY !== 1'b1) begin
            fails++; $display("FAIL midrst_check_hold: tap=%0d busy=%0b expected 3/1", oTAP, oBUSY);
        end
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
        tests++; if (oTAP !== 3'd4 || oBUSY !== 1'b0 || oLOCK !== 1'b0 || oFAIL !== 1'b0) begin
            fails++; $display("FAIL midrst_abort: tap=%0d busy=%0b lock=%0b fail=%0b expected 4/0/0/0", oTAP, oBUSY, oLOCK, oFAIL);
        end
        tests++; if (oEYE_START !== 3'd0 || oEYE_WIDTH !== 4'd0) begin
            fails++; $display("FAIL midrst_eye: start=%0d width=%0d expected 0/0", oEYE_START, oEYE_WIDTH);
        end
        run_cal(0, cycles, timedOut, busyAtDone, extra, bE, lE, fE);
        tests++; if (timedOut || cycles != 658 || extra != 0) begin
            fails++; $display("FAIL midrst_rerun: timeout=%0b cycles=%0d extra=%0d expected 0/658/0", timedOut, cycles, extra);
        end
        tests++; if (oLOCK !== 1'b1 || oTAP !== 3'd4 || oEYE_START !== 3'd2 || oEYE_WIDTH !== 4'd5) begin
            fails++; $display("FAIL midrst_result: lock=%0b tap=%0d start=%0d width=%0d expected 1/4/2/5", oLOCK, oTAP, oEYE_START, oEYE_WIDTH);
        end
    endtask

    initial begin
        iRST   = 1'b1;
        iSTART = 1'b0;
        test_reset();
        test_single_eye();
        test_tie();
        test_narrow();
        test_gaps_retrigger();
        test_reset_mid_check();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pclk_tap_calibrator.md
Name: pclk_tap_calibrator

Overview:
- Calibrates the capture phase of the D8M camera pixel clock.
- Drives the tap select of a multi-tap lcell delay line, for example an 8-tap variant of the clock-delay chain.
- Checks the returned parallel pixel bus against an alternating training pattern at each tap.
- Finds the longest contiguous passing window (the eye), then parks the tap at the centre of that window.
- Sits between the camera bridge capture path and the tap-selectable delay line, and runs once after sensor configuration.

Parameters:
- NUM_TAPS, 8, number of selectable delay taps (2..16).
- TAP_W, 3, width of the tap select; must satisfy 2^TAP_W >= NUM_TAPS.
- DATA_W, 10, pixel bus width.
- PAT_A, 10'h2AA, first training word; the second training word is ~PAT_A.
- SETTLE, 16, cycles to wait after each tap change before checking.
- SAMPLES, 64, valid words that must be checked per tap.
- MIN_EYE, 2, minimum eye width (in taps) for lock.
- DEF_TAP, 4, tap used after reset and after a failed calibration.

Ports:
- iCLK  in  1  pixel-domain clock.
- iRST  in  1  synchronous reset, active-high.
- iSTART  in  1  single-cycle pulse that starts calibration; ignored while oBUSY=1.
- iDATA  in  DATA_W  pixel word sampled with the current tap.
- iDVAL  in  1  iDATA is valid this cycle.
- oTAP  out  TAP_W  tap select driven to the delay line.
- oBUSY  out  1  calibration in progress.
- oDONE  out  1  single-cycle pulse when calibration ends (pass or fail).
- oLOCK  out  1  the last calibration passed.
- oFAIL  out  1  the last calibration failed.
- oEYE_START  out  TAP_W  first tap of the chosen eye.
- oEYE_WIDTH  out  TAP_W+1  number of taps in the chosen eye.

Behaviour:
- Reset (iRST=1 at a rising edge of iCLK): oTAP=DEF_TAP; oBUSY, oDONE, oLOCK and oFAIL are 0; oEYE_START=0; oEYE_WIDTH=0; FSM goes to IDLE. Reset mid-calibration aborts it with the same values.
- FSM states: IDLE, SETTLE, CHECK, NEXT, PICK, FINISH.
- IDLE: on iSTART, set oTAP=0 and tap index=0, clear the run and best registers and oLOCK/oFAIL, set oBUSY=1, go to SETTLE.
- SETTLE: count SETTLE cycles, ignoring iDATA. Then clear the per-tap error flag and sample counter, clear the "previous word valid" flag, go to CHECK.
- CHECK: count only cycles with iDVAL=1.
  - The first valid word passes if it equals PAT_A or ~PAT_A.
  - Each later valid word passes only if it equals the bitwise inverse of the previous valid word.
  - Any mismatch sets the error flag.
  - Cycles with iDVAL=0 do not advance the counter and do not break the alternation.
  - After SAMPLES valid words, go to NEXT. There is no timeout; the bench must supply data.
- NEXT:
  - Pass (no error): increment the run length; on the first pass of a run, record the run start.
  - Fail: the run length becomes 0.
  - If the run length is strictly greater than the best, copy the run into the best registers. Ties keep the earlier (lower-tap) eye.
  - If the tap index equals NUM_TAPS-1, go to PICK. Otherwise increment the tap index and oTAP, then go to SETTLE.
  - Runs do not wrap from the last tap back to tap 0.
- PICK:
  - Lock when the best width >= MIN_EYE: oTAP = best_start + (best_width-1)>>1, oLOCK=1.
  - Otherwise: oTAP=DEF_TAP, oFAIL=1.
  - oEYE_START and oEYE_WIDTH take the best values; both are 0 when no tap passed.
- FINISH: oDONE=1 for exactly one cycle, oBUSY=0 in that same cycle, then return to IDLE.
- Latency: (SETTLE+1) cycles plus SAMPLES valid cycles plus 1 cycle per tap, plus 2 cycles.
- Retrigger: iSTART while busy is ignored. iSTART in the FINISH cycle is ignored. iSTART in IDLE always restarts; oLOCK and oFAIL clear on that restart.
- oTAP changes only in IDLE→SETTLE, NEXT and PICK, and never changes during CHECK.
- Output stability: between calibrations oTAP, oLOCK, oFAIL and the eye outputs hold their values.
- Arithmetic: all counters are unsigned and saturating-free. Widths are sized so SETTLE and SAMPLES fit: $clog2(value)+1 bits.

Test Plan:
- Reset then idle → oTAP=4, oBUSY=0, oLOCK=0, oFAIL=0; oDONE never pulses without iSTART.
- Model passes taps 2..6 (clean 2AA/155 alternation), corrupts the others → oDONE once, oLOCK=1, oEYE_START=2, oEYE_WIDTH=5, oTAP=4.
- Two eyes, taps 0-1 and 5-6 → tie keeps the first: oEYE_START=0, oEYE_WIDTH=2, oTAP=0.
- Only tap 7 passes → width 1 < MIN_EYE: oFAIL=1, oTAP=4, oEYE_START=7, oEYE_WIDTH=1.
- Passing taps with iDVAL gaps (1 valid in 3), plus a second iSTART mid-run → gaps do not fail any tap; the second iSTART is ignored; oDONE pulses exactly once.
- Assert iRST during CHECK at tap 3 → next cycle oTAP=4, oBUSY=0; a fresh iSTART completes normally.
